pass_sequencer: RTL and testbench

//  Datapath-side responder to the training state machine. Consumes pass levels (f0/f1/b) and

---
 rtl/train_pkg.sv | 22 ++
 rtl/sat_mac.sv | 40 ++++
 rtl/pass_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pass_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/train_pkg.sv
// Shared types and widths for the training controller and its datapath responder.
// Holds the sequencer state encoding and the pass-level helpers.
package train_pkg;

    localparam int TRAIN_DATA_W = 8;
    localparam int TRAIN_ACC_W  = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_F_LAST,
        S_F_DONE,
        S_BWD,
        S_B_LAST,
        S_B_DONE
    } seq_state_t;

    function automatic logic [1:0] pass_count(input logic a, input logic b, input logic c);
        return 2'(a) + 2'(b) + 2'(c);
    endfunction

endpackage

// File: rtl/sat_mac.sv
// Signed y = sat_OUT_W(c + ((a*b) >>> SHIFT)); purely combinational, no flow control.
// The product is kept at full width before the shift, so no bits are lost ahead of the add.
module sat_mac #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int C_W   = 20,
    parameter int OUT_W = 20,
    parameter int SHIFT = 0
) (
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    input  logic signed [C_W-1:0]   c,
    output logic signed [OUT_W-1:0] y
);
    localparam int P_W   = A_W + B_W;
    localparam int SUM_W = ((P_W > C_W) ? P_W : C_W) + 1;

    logic signed [P_W-1:0]   a_ext;
    logic signed [P_W-1:0]   b_ext;
    logic signed [P_W-1:0]   prod;
    logic signed [P_W-1:0]   prod_sh;
    logic signed [SUM_W-1:0] sum;
    logic                    ovf;

    always_comb begin
        a_ext   = {{B_W{a[A_W-1]}}, a};
        b_ext   = {{A_W{b[B_W-1]}}, b};
        prod    = a_ext * b_ext;
        prod_sh = prod >>> SHIFT;
        sum     = {{(SUM_W-P_W){prod_sh[P_W-1]}}, prod_sh} + {{(SUM_W-C_W){c[C_W-1]}}, c};
        // Overflow when the bits above the output sign disagree with the true sign.
        ovf     = (sum[SUM_W-1:OUT_W-1] != {(SUM_W-OUT_W+1){sum[SUM_W-1]}});
        if (ovf) begin
            y = sum[SUM_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            y = sum[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/pass_sequencer.sv
// Datapath responder to the training controller: forward MAC sweep or backward weight update over N_IN operands.
// Operand reads have 1-cycle latency; en_i low freezes all state and blocks reads/writes; end levels held until the pass falls.
module pass_sequencer
    import train_pkg::*;
#(
    parameter int N_IN     = 4,
    parameter int AW       = 2,
    parameter int DATA_W   = TRAIN_DATA_W,
    parameter int ACC_W    = TRAIN_ACC_W,
    parameter int LR_SHIFT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     f0_pass_i,
    input  logic                     f1_pass_i,
    input  logic                     b_pass_i,
    input  logic                     zero_loss_i,
    input  logic                     zero_final_i,
    input  logic                     zero_weight_update_i,
    input  logic signed [DATA_W-1:0] target_i,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [DATA_W-1:0] w_i,
    output logic                     rd_en_o,
    output logic [AW-1:0]            addr_o,
    output logic                     w_we_o,
    output logic [AW-1:0]            waddr_o,
    output logic signed [DATA_W-1:0] wdata_o,
    output logic                     f_end_o,
    output logic                     b_end_o,
    output logic                     zero_end_check_o,
    output logic signed [ACC_W-1:0]  loss_o,
    output logic [15:0]              epoch_o,
    output logic                     err_o
);
    localparam logic [AW-1:0] IDX_LAST = AW'(N_IN - 1);

    seq_state_t               state, state_nxt;
    logic [AW-1:0]            idx;
    logic [AW-1:0]            waddr_q;
    logic                     rd_vld;
    logic                     run_f1;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  loss;
    logic [15:0]              epoch;
    logic                     err;

    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W:0]    diff;
    logic signed [ACC_W-1:0]  loss_next;
    logic signed [DATA_W-1:0] w_upd;
    logic [1:0]               n_pass;
    logic                     bwd_run;
    logic                     launch_hi;
    logic                     other_hi;
    logic                     mac_en;
    logic                     loss_en;
    logic                     idx_clr;
    logic                     idx_inc;
    logic                     w_we;

    sat_mac #(.A_W(DATA_W), .B_W(DATA_W), .C_W(ACC_W), .OUT_W(ACC_W), .SHIFT(0)) u_fwd_mac (
        .a(x_i), .b(w_i), .c(acc), .y(acc_next)
    );

    sat_mac #(.A_W(ACC_W), .B_W(DATA_W), .C_W(DATA_W), .OUT_W(DATA_W), .SHIFT(LR_SHIFT)) u_upd_mac (
        .a(loss), .b(x_i), .c(w_i), .y(w_upd)
    );

    always_comb begin
        diff = {{(ACC_W+1-DATA_W){target_i[DATA_W-1]}}, target_i} - {acc_next[ACC_W-1], acc_next};
        if (diff[ACC_W] != diff[ACC_W-1]) begin
            loss_next = diff[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            loss_next = diff[ACC_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en_o   = 1'b0;
        w_we      = 1'b0;
        mac_en    = 1'b0;
        loss_en   = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        n_pass    = pass_count(f0_pass_i, f1_pass_i, b_pass_i);
        bwd_run   = (state == S_BWD) || (state == S_B_LAST) || (state == S_B_DONE);
        launch_hi = bwd_run ? b_pass_i : (run_f1 ? f1_pass_i : f0_pass_i);
        other_hi  = bwd_run ? (f0_pass_i | f1_pass_i)
                            : (b_pass_i | (run_f1 ? f0_pass_i : f1_pass_i));
        case (state)
            S_IDLE: begin
                idx_clr = 1'b1;
                if (n_pass == 2'd1) state_nxt = b_pass_i ? S_BWD : S_FWD;
            end
            S_FWD, S_BWD: begin
                if (!launch_hi) begin
                    state_nxt = S_IDLE;
                end else begin
                    rd_en_o = 1'b1;
                    mac_en  = rd_vld && (state == S_FWD);
                    w_we    = rd_vld && (state == S_BWD);
                    idx_inc = (idx != IDX_LAST);
                    if (idx == IDX_LAST) state_nxt = (state == S_FWD) ? S_F_LAST : S_B_LAST;
                end
            end
            S_F_LAST: begin
                if (!launch_hi) begin
                    state_nxt = S_IDLE;
                end else begin
                    mac_en    = 1'b1;
                    loss_en   = 1'b1;
                    state_nxt = S_F_DONE;
                end
            end
            S_B_LAST: begin
                if (!launch_hi) begin
                    state_nxt = S_IDLE;
                end else begin
                    w_we      = 1'b1;
                    state_nxt = S_B_DONE;
                end
            end
            S_F_DONE, S_B_DONE: begin
                if (!launch_hi || other_hi) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!en_i) begin
            rd_en_o = 1'b0;
            w_we    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            idx     <= '0;
            waddr_q <= '0;
            rd_vld  <= 1'b0;
            run_f1  <= 1'b0;
            acc     <= '0;
            loss    <= '0;
            epoch   <= '0;
            err     <= 1'b0;
        end else if (en_i) begin
            state  <= state_nxt;
            rd_vld <= rd_en_o;
            if (idx_clr) idx <= '0;
            else if (idx_inc) idx <= idx + 1'b1;
            if (rd_en_o) waddr_q <= idx;
            if (state == S_IDLE) run_f1 <= f1_pass_i;
            if (zero_final_i) acc <= '0;
            else if (mac_en) acc <= acc_next;
            if (zero_loss_i) loss <= '0;
            else if (loss_en) loss <= loss_next;
            if (zero_weight_update_i) epoch <= epoch + 16'd1;
            if (n_pass > 2'd1) err <= 1'b1;
        end
    end

    assign w_we_o           = w_we;
    assign addr_o           = idx;
    assign waddr_o          = waddr_q;
    assign wdata_o          = w_we ? w_upd : '0;
    assign f_end_o          = (state == S_F_DONE) && (!run_f1 || (loss != '0));
    assign zero_end_check_o = (state == S_F_DONE) && run_f1 && (loss == '0);
    assign b_end_o          = (state == S_B_DONE);
    assign loss_o           = loss;
    assign epoch_o          = epoch;
    assign err_o            = err;

endmodule

// File: tb/tb_pass_sequencer.sv
// Directed bench for pass_sequencer: forward/backward sweeps, aborts, stalls, reset and clear strobes.
module tb_pass_sequencer;

    logic              clk_i = 1'b0;
    logic              rst_i, en_i;
    logic              f0_pass_i, f1_pass_i, b_pass_i;
    logic              zero_loss_i, zero_final_i, zero_weight_update_i;
    logic signed [7:0] target_i;
    logic signed [7:0] x_i = '0;
    logic signed [7:0] w_i = '0;
    logic              rd_en_o, w_we_o;
    logic [1:0]        addr_o, waddr_o;
    logic signed [7:0] wdata_o;
    logic              f_end_o, b_end_o, zero_end_check_o;
    logic signed [19:0] loss_o;
    logic [15:0]       epoch_o;
    logic              err_o;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    logic signed [7:0] xm [4];
    logic signed [7:0] wm [4];
    int                rd_cnt = 0;
    int                wr_cnt = 0;
    logic [1:0]        wa [64];
    logic signed [7:0] wd [64];

    always #5 clk_i = ~clk_i;

    pass_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
        .f0_pass_i(f0_pass_i), .f1_pass_i(f1_pass_i), .b_pass_i(b_pass_i),
        .zero_loss_i(zero_loss_i), .zero_final_i(zero_final_i),
        .zero_weight_update_i(zero_weight_update_i),
        .target_i(target_i), .x_i(x_i), .w_i(w_i),
        .rd_en_o(rd_en_o), .addr_o(addr_o), .w_we_o(w_we_o), .waddr_o(waddr_o),
        .wdata_o(wdata_o), .f_end_o(f_end_o), .b_end_o(b_end_o),
        .zero_end_check_o(zero_end_check_o), .loss_o(loss_o), .epoch_o(epoch_o),
        .err_o(err_o)
    );

    // Operand memory: registered read, output held between reads.
    always @(posedge clk_i) begin
        if (rd_en_o) begin
            x_i <= xm[addr_o];
            w_i <= wm[addr_o];
        end
    end

    always @(negedge clk_i) begin
        if (rd_en_o) rd_cnt = rd_cnt + 1;
        if (w_we_o && wr_cnt < 64) begin
            wa[wr_cnt] = waddr_o;
            wd[wr_cnt] = wdata_o;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_mem(input logic signed [7:0] x0, x1, x2, x3, w0, w1, w2, w3);
        xm[0] = x0; xm[1] = x1; xm[2] = x2; xm[3] = x3;
        wm[0] = w0; wm[1] = w1; wm[2] = w2; wm[3] = w3;
    endtask

    task automatic pulse_zero_final;
        zero_final_i = 1'b1;
        tick();
        zero_final_i = 1'b0;
    endtask

    task automatic run_until_end(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(f_end_o || b_end_o || zero_end_check_o) && n < 40);
    endtask

    initial begin
        int n, r0, w0;
        logic [1:0]        exp_a [4];
        logic signed [7:0] exp_d [4];

        rst_i = 1'b0; en_i = 1'b1;
        f0_pass_i = 1'b0; f1_pass_i = 1'b0; b_pass_i = 1'b0;
        zero_loss_i = 1'b0; zero_final_i = 1'b0; zero_weight_update_i = 1'b0;
        target_i = 8'sd0;
        set_mem(1, 2, 3, 4, 1, 1, 1, 1);
        tick(); tick();
        check("reset_flags", {rd_en_o, w_we_o, f_end_o, b_end_o, zero_end_check_o, err_o}, 0);
        check("reset_loss", loss_o, 0);
        check("reset_epoch", epoch_o, 0);
        rst_i = 1'b1;
        tick();

        // f0 sweep: acc = 1+2+3+4 = 10, target 10 -> loss 0, f_end
        pulse_zero_final();
        target_i = 8'sd10;
        r0 = rd_cnt;
        f0_pass_i = 1'b1;
        run_until_end(n);
        check("t1_cycles", n, 6);  // launch edge + N_IN+1 sweep cycles
        check("t1_reads", rd_cnt - r0, 4);
        check("t1_loss", loss_o, 0);
        check("t1_fend", f_end_o, 1);
        check("t1_zec", zero_end_check_o, 0);
        tick(); tick();
        check("t1_fend_held", f_end_o, 1);
        f0_pass_i = 1'b0;
        tick();
        check("t1_fend_clear", f_end_o, 0);

        // f1 sweep with zero loss, then with loss 2
        pulse_zero_final();
        f1_pass_i = 1'b1;
        run_until_end(n);
        check("t2_zec", zero_end_check_o, 1);
        check("t2_fend0", f_end_o, 0);
        f1_pass_i = 1'b0;
        tick();
        pulse_zero_final();
        target_i = 8'sd12;
        f1_pass_i = 1'b1;
        run_until_end(n);
        check("t2_loss2", loss_o, 2);
        check("t2_fend1", f_end_o, 1);
        check("t2_zec0", zero_end_check_o, 0);
        f1_pass_i = 1'b0;
        tick();
        zero_loss_i = 1'b1;
        tick();
        zero_loss_i = 1'b0;
        check("zero_loss_clear", loss_o, 0);

        // backward sweep: loss 32, x 16 -> (32*16)>>>4 = 32 added to each weight
        pulse_zero_final();
        target_i = 8'sd42;
        f0_pass_i = 1'b1;
        run_until_end(n);
        check("t3_loss32", loss_o, 32);
        f0_pass_i = 1'b0;
        tick();
        set_mem(16, 16, 16, 16, 1, -5, 50, 120);
        exp_a = '{2'd0, 2'd1, 2'd2, 2'd3};
        exp_d = '{8'sd33, 8'sd27, 8'sd82, 8'sd127};
        w0 = wr_cnt;
        b_pass_i = 1'b1;
        run_until_end(n);
        check("t3_cycles", n, 6);
        check("t3_bend", b_end_o, 1);
        check("t3_writes", wr_cnt - w0, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_waddr%0d", i), wa[w0+i], exp_a[i]);
            check($sformatf("t3_wdata%0d", i), wd[w0+i], exp_d[i]);
        end
        b_pass_i = 1'b0;
        tick();
        check("t3_bend_clear", b_end_o, 0);

        // abort after two reads, then conflicting passes
        set_mem(1, 2, 3, 4, 1, 1, 1, 1);
        r0 = rd_cnt;
        w0 = wr_cnt;
        f0_pass_i = 1'b1;
        tick(); tick(); tick();
        f0_pass_i = 1'b0;
        #1;
        check("t4_rd_gated", rd_en_o, 0);
        tick(); tick(); tick();
        check("t4_reads", rd_cnt - r0, 2);
        check("t4_writes", wr_cnt - w0, 0);
        check("t4_no_end", {f_end_o, zero_end_check_o}, 0);
        f0_pass_i = 1'b1;
        b_pass_i = 1'b1;
        tick();
        check("t4_err", err_o, 1);
        check("t4_err_idle", rd_en_o, 0);
        f0_pass_i = 1'b0;
        b_pass_i = 1'b0;
        tick(); tick();
        check("t4_err_sticky", err_o, 1);

        // stall three cycles mid-forward
        pulse_zero_final();
        target_i = 8'sd10;
        r0 = rd_cnt;
        f0_pass_i = 1'b1;
        tick(); tick();
        en_i = 1'b0;
        #1;
        check("t5_rd_off", rd_en_o, 0);
        tick();
        check("t5_addr_frozen", addr_o, 1);
        tick(); tick();
        check("t5_rd_off_late", rd_en_o, 0);
        check("t5_addr_frozen_late", addr_o, 1);
        en_i = 1'b1;
        run_until_end(n);
        check("t5_cycles", n, 4);
        check("t5_reads", rd_cnt - r0, 4);
        check("t5_loss", loss_o, 0);
        check("t5_fend", f_end_o, 1);
        f0_pass_i = 1'b0;
        tick();

        // epoch counting, reset mid-backward
        repeat (3) begin
            zero_weight_update_i = 1'b1;
            tick();
        end
        zero_weight_update_i = 1'b0;
        check("t6_epoch3", epoch_o, 3);
        b_pass_i = 1'b1;
        tick(); tick(); tick();
        check("t6_bwd_writing", w_we_o, 1);
        rst_i = 1'b0;
        tick();
        check("t6_rst_flags", {rd_en_o, w_we_o, f_end_o, b_end_o, zero_end_check_o, err_o}, 0);
        check("t6_rst_addr", {addr_o, waddr_o}, 0);
        check("t6_rst_wdata", wdata_o, 0);
        check("t6_rst_epoch", epoch_o, 0);
        check("t6_rst_loss", loss_o, 0);
        b_pass_i = 1'b0;
        rst_i = 1'b1;
        tick();

        // clear during the x2 MAC: acc restarts at 0, final acc = 4, loss = 10 - 4
        f0_pass_i = 1'b1;
        tick(); tick(); tick(); tick();
        zero_final_i = 1'b1;
        tick();
        zero_final_i = 1'b0;
        run_until_end(n);
        check("t6_clear_beats_mac", loss_o, 6);
        check("t6_clear_fend", f_end_o, 1);
        f0_pass_i = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
